// File: rtl/poly_dds_bank.sv
// Polyphonic DDS phase-accumulator bank: one shared adder sweeps all voices per
// sample tick, two cycles per voice (store read, then update and write-back).
module poly_dds_bank #(
  parameter int  NUM_VOICES = 16,
  parameter int  ACC_W      = 32,
  parameter int  OUT_W      = 10,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             cfg_we,
  input  logic             cfg_sync,
  input  logic [VW-1:0]    cfg_addr,
  input  logic [ACC_W-1:0] cfg_delta,
  output logic             out_valid,
  output logic [VW-1:0]    out_voice,
  output logic [OUT_W-1:0] out_phase,
  output logic             out_wrap,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);
  localparam logic [VW:0]   NV_EXT = (VW + 1)'(NUM_VOICES);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_UPDATE} state_t;

  state_t                state;
  logic [VW-1:0]         v;
  logic [VW-1:0]         init_cnt;
  logic [NUM_VOICES-1:0] pending;

  logic [ACC_W-1:0] acc_mem   [NUM_VOICES];
  logic [ACC_W-1:0] delta_mem [NUM_VOICES];
  logic [ACC_W-1:0] acc_rd;
  logic [ACC_W-1:0] delta_rd;
  logic [ACC_W:0]   sum;
  logic             cfg_ok;

  // Config port is dead during INIT and for addresses past the last voice.
  assign cfg_ok = (state != S_INIT) && ({1'b0, cfg_addr} < NV_EXT);
  assign busy   = (state != S_IDLE);

  // A pending sync restarts the voice from phase 0, so the carry is always clear.
  always_comb begin
    sum = {1'b0, acc_rd} + {1'b0, delta_rd};
    if (pending[v]) sum = {1'b0, delta_rd};
  end

  // NOTE: the store arrays have no reset; their contents are defined by the INIT sweep.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      acc_mem[init_cnt]   <= '0;
      delta_mem[init_cnt] <= '0;
    end else begin
      if (state == S_UPDATE) acc_mem[v] <= sum[ACC_W-1:0];
      if (cfg_we && cfg_ok)  delta_mem[cfg_addr] <= cfg_delta;
    end
    if (state == S_READ) begin
      acc_rd   <= acc_mem[v];
      delta_rd <= delta_mem[v];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      v          <= '0;
      pending    <= '0;
      overrun    <= 1'b0;
      out_valid  <= 1'b0;
      out_voice  <= '0;
      out_phase  <= '0;
      out_wrap   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (tick && (state == S_READ || state == S_UPDATE)) overrun <= 1'b1;

      case (state)
        S_INIT: begin
          if (init_cnt == LAST_V) state <= S_IDLE;
          else                    init_cnt <= init_cnt + VW'(1);
        end
        S_IDLE: begin
          if (tick) begin
            v     <= '0;
            state <= S_READ;
          end
        end
        S_READ: state <= S_UPDATE;
        S_UPDATE: begin
          out_valid <= 1'b1;
          out_voice <= v;
          out_phase <= sum[ACC_W-1 -: OUT_W];
          out_wrap  <= sum[ACC_W];
          if (v == LAST_V) begin
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end else begin
            v     <= v + VW'(1);
            state <= S_READ;
          end
        end
        default: state <= S_INIT;
      endcase

      // NOTE: the set is written after the clear so that, as the later non-blocking
      // assignment, it wins when both hit the same voice in one cycle.
      if (state == S_UPDATE) pending[v] <= 1'b0;
      if (cfg_sync && cfg_ok) pending[cfg_addr] <= 1'b1;
    end
  end

endmodule
